// File: rtl/amber48_mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one shared memory bus, one transaction in flight, alternating on contention.
// Optional ISSUE-phase grant timeout is compiled in when AMBER48_ARB_TIMEOUT_EN is defined.
module amber48_mem_arbiter #(
   parameter int XLEN           = 48,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            imem_req_i,
   input  logic [XLEN-1:0] imem_addr_i,
   output logic [XLEN-1:0] imem_data_o,
   output logic            imem_valid_o,
   output logic            imem_err_o,
   input  logic            dmem_req_i,
   input  logic            dmem_we_i,
   input  logic [XLEN-1:0] dmem_addr_i,
   input  logic [XLEN-1:0] dmem_wdata_i,
   output logic [XLEN-1:0] dmem_rdata_o,
   output logic            dmem_ready_o,
   output logic            dmem_trap_o,
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [XLEN-1:0] mem_addr_o,
   output logic [XLEN-1:0] mem_wdata_o,
   input  logic            mem_gnt_i,
   input  logic            mem_rvalid_i,
   input  logic [XLEN-1:0] mem_rdata_i,
   input  logic            mem_err_i
);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
   localparam logic OWN_IMEM = 1'b0;
   localparam logic OWN_DMEM = 1'b1;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be within 1..255");
   end

   state_t          state_q;
   logic            owner_q, last_owner_q;
   logic [XLEN-1:0] addr_q, wdata_q;
   logic            we_q, mem_req_q;
   logic [XLEN-1:0] imem_data_q, dmem_data_q;
   logic            imem_valid_q, imem_err_q, dmem_ready_q, dmem_trap_q;
   logic            grant_dmem_d, tmo_hit_d, resp_fire_d, resp_err_d;
   logic [XLEN-1:0] resp_data_d;

`ifdef AMBER48_ARB_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] tmo_cnt_q;
   // Fires in the last allowed ungranted ISSUE cycle; a grant in that same cycle still wins.
   assign tmo_hit_d = (state_q == S_ISSUE) && !mem_gnt_i && (tmo_cnt_q >= TMO_LAST);
`else
   assign tmo_hit_d = 1'b0;
`endif

   assign grant_dmem_d = dmem_req_i && (!imem_req_i || last_owner_q == OWN_IMEM);

   always_comb begin
      resp_fire_d = 1'b0;
      resp_data_d = mem_rdata_i;
      resp_err_d  = mem_err_i;
      if (tmo_hit_d) begin
         resp_fire_d = 1'b1;
         resp_data_d = '0;
         resp_err_d  = 1'b1;
      end else if (state_q == S_ISSUE) begin
         resp_fire_d = mem_gnt_i && mem_rvalid_i;
      end else if (state_q == S_WAIT) begin
         resp_fire_d = mem_rvalid_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         owner_q      <= OWN_IMEM;
         last_owner_q <= OWN_IMEM;
         addr_q       <= '0;
         wdata_q      <= '0;
         we_q         <= 1'b0;
         mem_req_q    <= 1'b0;
         imem_data_q  <= '0;
         dmem_data_q  <= '0;
         imem_valid_q <= 1'b0;
         imem_err_q   <= 1'b0;
         dmem_ready_q <= 1'b0;
         dmem_trap_q  <= 1'b0;
      end else begin
         imem_valid_q <= 1'b0;
         imem_err_q   <= 1'b0;
         dmem_ready_q <= 1'b0;
         dmem_trap_q  <= 1'b0;
         // Response registers load on entry to RESP so the pulse lands in the RESP cycle.
         if (resp_fire_d) begin
            if (owner_q == OWN_DMEM) begin
               dmem_ready_q <= 1'b1;
               dmem_trap_q  <= resp_err_d;
               dmem_data_q  <= resp_data_d;
            end else begin
               imem_valid_q <= 1'b1;
               imem_err_q   <= resp_err_d;
               imem_data_q  <= resp_data_d;
            end
         end
         case (state_q)
            S_IDLE: begin
               if (imem_req_i || dmem_req_i) begin
                  owner_q      <= grant_dmem_d;
                  last_owner_q <= grant_dmem_d;
                  addr_q       <= grant_dmem_d ? dmem_addr_i : imem_addr_i;
                  we_q         <= grant_dmem_d && dmem_we_i;
                  wdata_q      <= grant_dmem_d ? dmem_wdata_i : '0;
                  mem_req_q    <= 1'b1;
                  state_q      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (mem_gnt_i) begin
                  mem_req_q <= 1'b0;
                  state_q   <= mem_rvalid_i ? S_RESP : S_WAIT;
               end else if (tmo_hit_d) begin
                  mem_req_q <= 1'b0;
                  state_q   <= S_RESP;
               end
            end
            S_WAIT:  if (mem_rvalid_i) state_q <= S_RESP;
            S_RESP:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef AMBER48_ARB_TIMEOUT_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tmo_cnt_q <= '0;
      end else if (state_q == S_ISSUE && !mem_gnt_i && !tmo_hit_d) begin
         tmo_cnt_q <= tmo_cnt_q + 8'd1;
      end else begin
         tmo_cnt_q <= '0;
      end
   end
`endif

   assign imem_data_o  = imem_data_q;
   assign imem_valid_o = imem_valid_q;
   assign imem_err_o   = imem_err_q;
   assign dmem_rdata_o = dmem_data_q;
   assign dmem_ready_o = dmem_ready_q;
   assign dmem_trap_o  = dmem_trap_q;
   assign mem_req_o    = mem_req_q;
   assign mem_we_o     = we_q;
   assign mem_addr_o   = addr_q;
   assign mem_wdata_o  = wdata_q;
endmodule

// File: tb/tb_amber48_mem_arbiter.sv
// Bench for amber48_mem_arbiter: schedule-based transaction model plus directed literal checks.
module tb_amber48_mem_arbiter;
   localparam int XLEN = 48;
`ifdef AMBER48_ARB_TIMEOUT_EN
   localparam int TMO = 3;
`else
   localparam int TMO = 15;
`endif

   logic            clk, rst;
   logic            imem_req_i, dmem_req_i, dmem_we_i;
   logic [XLEN-1:0] imem_addr_i, dmem_addr_i, dmem_wdata_i;
   logic            mem_gnt_i, mem_rvalid_i, mem_err_i;
   logic [XLEN-1:0] mem_rdata_i;
   logic [XLEN-1:0] imem_data_o, dmem_rdata_o, mem_addr_o, mem_wdata_o;
   logic            imem_valid_o, imem_err_o, dmem_ready_o, dmem_trap_o, mem_req_o, mem_we_o;

   amber48_mem_arbiter #(.XLEN(XLEN), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_i(clk), .rst_i(rst),
      .imem_req_i(imem_req_i), .imem_addr_i(imem_addr_i), .imem_data_o(imem_data_o),
      .imem_valid_o(imem_valid_o), .imem_err_o(imem_err_o),
      .dmem_req_i(dmem_req_i), .dmem_we_i(dmem_we_i), .dmem_addr_i(dmem_addr_i),
      .dmem_wdata_i(dmem_wdata_i), .dmem_rdata_o(dmem_rdata_o), .dmem_ready_o(dmem_ready_o),
      .dmem_trap_o(dmem_trap_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // Transaction model: one record, described by its timeline (issue start, grant, response).
   int              cyc;
   bit              act, tmo, own, last_own;
   int              s, g_cyc, rv_cyc, r_cyc;
   logic [XLEN-1:0] m_addr, m_wdata, m_rdata, exp_idata, exp_ddata;
   bit              m_we, m_err;
   bit              plan_rnd, rnd_req, hold_req;
   int              plan_gd, plan_rd;
   logic [XLEN-1:0] plan_rdata;
   bit              plan_err;
   int              req_cycles, we_cycles;

   typedef struct {
      int              c;
      bit              o;
      logic [XLEN-1:0] d;
      bit              e;
   } pulse_t;
   pulse_t log_q[$];

   function automatic logic [XLEN-1:0] rnd48();
      logic [63:0] t;
      t = {$urandom, $urandom};
      return t[XLEN-1:0];
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s cyc=%0d: got %h want %h", name, cyc, got, want);
      end
   endtask

   task automatic check_cycle();
      bit exp_req, exp_iv, exp_dv;
      pulse_t p;
      exp_req = act && cyc >= s && cyc <= (tmo ? s + TMO - 1 : g_cyc);
      check("mem_req", mem_req_o, exp_req);
      if (exp_req) begin
         check("mem_addr", mem_addr_o, m_addr);
         check("mem_we", mem_we_o, m_we);
         check("mem_wdata", mem_wdata_o, m_wdata);
      end
      exp_iv = act && cyc == r_cyc && own == 1'b0;
      exp_dv = act && cyc == r_cyc && own == 1'b1;
      check("imem_valid", imem_valid_o, exp_iv);
      check("dmem_ready", dmem_ready_o, exp_dv);
      if (exp_iv) begin
         exp_idata = m_rdata;
         check("imem_err", imem_err_o, m_err);
      end
      if (exp_dv) begin
         exp_ddata = m_rdata;
         check("dmem_trap", dmem_trap_o, m_err);
      end
      check("imem_data", imem_data_o, exp_idata);
      check("dmem_rdata", dmem_rdata_o, exp_ddata);
      if (mem_req_o) req_cycles++;
      if (mem_req_o && mem_we_o) we_cycles++;
      if (imem_valid_o) begin
         p.c = cyc; p.o = 1'b0; p.d = imem_data_o; p.e = imem_err_o;
         log_q.push_back(p);
      end
      if (dmem_ready_o) begin
         p.c = cyc; p.o = 1'b1; p.d = dmem_rdata_o; p.e = dmem_trap_o;
         log_q.push_back(p);
      end
   endtask

   task automatic drive_cycle();
      bit fin, inf_i, inf_d, in_win;
      int gd, rd;
      fin = act && cyc == r_cyc;
      if (fin && !hold_req) begin
         if (own) dmem_req_i = 1'b0;
         else     imem_req_i = 1'b0;
      end
      if (rnd_req) begin
         inf_i = act && own == 1'b0;
         inf_d = act && own == 1'b1;
         if (!imem_req_i) begin
            if (!inf_i && $urandom_range(3) == 0) begin
               imem_req_i = 1'b1; imem_addr_i = rnd48();
            end
         end else if (!inf_i && $urandom_range(15) == 0) imem_req_i = 1'b0;
         else if (inf_i && !fin && $urandom_range(7) == 0) imem_req_i = 1'b0;
         if (!dmem_req_i) begin
            if (!inf_d && $urandom_range(3) == 0) begin
               dmem_req_i = 1'b1; dmem_addr_i = rnd48(); dmem_wdata_i = rnd48();
               dmem_we_i = 1'($urandom_range(1));
            end
         end else if (!inf_d && $urandom_range(15) == 0) dmem_req_i = 1'b0;
         else if (inf_d && !fin && $urandom_range(7) == 0) dmem_req_i = 1'b0;
      end
      if (!act && (imem_req_i || dmem_req_i)) begin
         own      = (imem_req_i && dmem_req_i) ? ~last_own : dmem_req_i;
         last_own = own;
         m_addr   = own ? dmem_addr_i : imem_addr_i;
         m_we     = own ? dmem_we_i : 1'b0;
         m_wdata  = own ? dmem_wdata_i : '0;
         if (plan_rnd) begin
            gd = $urandom_range(0, 6); rd = $urandom_range(0, 3);
            m_rdata = rnd48(); m_err = ($urandom_range(3) == 0);
         end else begin
            gd = plan_gd; rd = plan_rd; m_rdata = plan_rdata; m_err = plan_err;
         end
         s = cyc + 1; g_cyc = s + gd; rv_cyc = g_cyc + rd; r_cyc = rv_cyc + 1; tmo = 1'b0;
`ifdef AMBER48_ARB_TIMEOUT_EN
         if (gd >= TMO) begin
            tmo = 1'b1; r_cyc = s + TMO; m_rdata = '0; m_err = 1'b1;
         end
`endif
         act = 1'b1;
      end
      in_win = act && cyc >= s && cyc < r_cyc;
      if (in_win) begin
         mem_gnt_i    = !tmo && cyc == g_cyc;
         mem_rvalid_i = !tmo && cyc == rv_cyc;
         mem_rdata_i  = mem_rvalid_i ? m_rdata : rnd48();
         mem_err_i    = mem_rvalid_i ? m_err : 1'($urandom_range(1));
      end else begin
         mem_gnt_i    = ($urandom_range(3) == 0);
         mem_rvalid_i = ($urandom_range(3) == 0);
         mem_rdata_i  = rnd48();
         mem_err_i    = 1'($urandom_range(1));
      end
      if (fin) act = 1'b0;
   endtask

   task automatic step();
      check_cycle();
      drive_cycle();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      imem_req_i = 1'b0; dmem_req_i = 1'b0; dmem_we_i = 1'b0;
      mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_err_i = 1'b1; mem_rdata_i = rnd48();
      #1;
      check("reset_outputs", |{mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, imem_data_o, imem_valid_o,
                               imem_err_o, dmem_rdata_o, dmem_ready_o, dmem_trap_o}, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      act = 1'b0; tmo = 1'b0; last_own = 1'b0; own = 1'b0;
      exp_idata = '0; exp_ddata = '0; cyc = 0;
      log_q.delete(); req_cycles = 0; we_cycles = 0;
      hold_req = 1'b0; rnd_req = 1'b0; plan_rnd = 1'b0;
   endtask

   task automatic run_until(input int n, input int budget);
      int k = 0;
      while (log_q.size() < n && k < budget) begin
         step();
         k++;
      end
      if (log_q.size() < n) begin
         total++; bad++;
         $display("FAIL wait_pulse: got %0d pulses want %0d within %0d cycles", log_q.size(), n, budget);
      end
   endtask

   initial begin
      rst = 1'b1;
      imem_addr_i = '0; dmem_addr_i = '0; dmem_wdata_i = '0;
      plan_gd = 0; plan_rd = 1; plan_rdata = '0; plan_err = 1'b0;

      // Single fetch, immediate bus.
      do_reset();
      plan_gd = 0; plan_rd = 1; plan_rdata = 48'h123456789ABC; plan_err = 1'b0;
      imem_req_i = 1'b1; imem_addr_i = 48'h000000000006;
      run_until(1, 20);
      if (log_q.size() >= 1) begin
         check("fetch_cycle", log_q[0].c, 3);
         check("fetch_owner", log_q[0].o, 1'b0);
         check("fetch_data", log_q[0].d, 48'h123456789ABC);
         check("fetch_err", log_q[0].e, 1'b0);
      end

      // Contention from reset with both held: D, I, D, I.
      do_reset();
      plan_gd = 0; plan_rd = 1; plan_rdata = 48'h0000AAAA5555;
      hold_req = 1'b1;
      imem_req_i = 1'b1; imem_addr_i = 48'h100;
      dmem_req_i = 1'b1; dmem_addr_i = 48'h200; dmem_we_i = 1'b0; dmem_wdata_i = 48'h7;
      run_until(4, 40);
      if (log_q.size() >= 4) begin
         check("alt_order", {log_q[0].o, log_q[1].o, log_q[2].o, log_q[3].o}, 4'b1010);
         check("alt_last_cycle", log_q[3].c, 15);
      end

      // Store with grant delayed 4 cycles.
      do_reset();
      plan_gd = 4; plan_rd = 1; plan_rdata = 48'h0BADC0FFEE00;
      dmem_req_i = 1'b1; dmem_we_i = 1'b1; dmem_addr_i = 48'h40; dmem_wdata_i = 48'hFFFF00000001;
      run_until(1, 30);
      repeat (5) step();
      check("store_req_cycles", req_cycles, 5);
      check("store_we_cycles", we_cycles, 5);
      check("store_pulses", log_q.size(), 1);

      // Faulting load then a clean load.
      do_reset();
      plan_gd = 0; plan_rd = 2; plan_rdata = 48'h111122223333; plan_err = 1'b1;
      dmem_req_i = 1'b1; dmem_we_i = 1'b0; dmem_addr_i = 48'h80;
      run_until(1, 20);
      plan_err = 1'b0; plan_rdata = 48'h444455556666;
      dmem_req_i = 1'b1; dmem_addr_i = 48'h88;
      run_until(2, 20);
      if (log_q.size() >= 2) begin
         check("trap_first", {log_q[0].o, log_q[0].e}, 2'b11);
         check("trap_second", {log_q[1].o, log_q[1].e}, 2'b10);
         check("trap_second_data", log_q[1].d, 48'h444455556666);
      end

      // Reset while waiting for the response; later bus activity must be ignored.
      do_reset();
      plan_gd = 0; plan_rd = 6; plan_rdata = 48'hDEAD;
      imem_req_i = 1'b1; imem_addr_i = 48'h300;
      repeat (4) step();
      do_reset();
      repeat (10) step();
      check("no_pulse_after_reset", log_q.size(), 0);

`ifdef AMBER48_ARB_TIMEOUT_EN
      do_reset();
      plan_gd = 1000; plan_rd = 0; plan_rdata = 48'h5A5A;
      dmem_req_i = 1'b1; dmem_we_i = 1'b0; dmem_addr_i = 48'h90;
      run_until(1, 20);
      if (log_q.size() >= 1) begin
         check("tmo_cycle", log_q[0].c, 1 + TMO);
         check("tmo_trap", {log_q[0].o, log_q[0].e}, 2'b11);
         check("tmo_data", log_q[0].d, 48'h0);
      end
`endif

      // Randomized traffic against the model.
      do_reset();
      plan_rnd = 1'b1; rnd_req = 1'b1;
      repeat (3000) step();
      check("rand_activity", log_q.size() > 100, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule
